fc_requant_pack: RTL and testbench
==================================

Name: fc_requant_pack

Overview:
Post-processing stage placed directly downstream of the first fully connected layer with ReLU.
- Reads that layer's 32-bit signed accumulator results from its output BRAM, one element per word.
- Requantises each element to an unsigned 8-bit activation by rounding, right-shifting and saturating.
- Packs four activations per 32-bit word and writes them to the input BRAM of the next fully connected layer, which consumes four bytes per word with the first element in bits [31:24].

Parameters:
DATA_WIDTH, 32, BRAM word width; fixed at 32 because of the four-byte packing.
ADDR_WIDTH, 12, BRAM address width.
NUM_ELEMS, 32, number of 32-bit results to convert; must be ≥1.
SHIFT, 8, requantisation right-shift amount, valid range 0..16.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
i_run  in  1  start pulse; sampled only in IDLE
ce_src  out  1  source BRAM clock enable
we_src  out  1  source BRAM write enable; tied to 0
addr_src  out  ADDR_WIDTH  source read address
din_src  out  DATA_WIDTH  tied to 0
qout_src  in  DATA_WIDTH  source read data (signed), valid 1 cycle after ce_src
ce_dst  out  1  destination BRAM clock enable
we_dst  out  1  destination BRAM write enable
addr_dst  out  ADDR_WIDTH  destination word address
din_dst  out  DATA_WIDTH  packed write data
busy  out  1  high from the cycle after i_run is accepted until layer_done
layer_done  out  1  one-cycle completion pulse

Behaviour:
Reset values:
- While reset=0, all outputs are 0, the FSM is in IDLE, and all counters and the pack register are cleared.
- Reset takes effect immediately, including mid-operation. No partial word is written after reset releases.

FSM states: IDLE, READ, DRAIN, DONE.
- IDLE → READ: on i_run=1.
- READ → DRAIN: after NUM_ELEMS read cycles.
- DRAIN → DONE: in the cycle after the final destination write.
- DONE → IDLE: unconditional; layer_done=1 only in DONE.
- i_run in any state other than IDLE is ignored.

Read side:
- In READ, ce_src=1 and addr_src = 0,1,…,NUM_ELEMS-1, one per cycle, with no gaps.
- A valid flag is delayed 1 cycle to mark when qout_src is valid.

Quantisation (combinational, on each valid qout_src value x):
- If x ≤ 0: q = 0.
- Otherwise: r = (x + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed at 33 bits so there is no overflow at 0x7FFFFFFF.
- q = min(r, 255).

Packing:
- A 2-bit byte counter selects the slot. Element 4k+j goes to din bits [31-8j : 24-8j].
- On the 4th byte, or on the element NUM_ELEMS-1, the assembled word is registered. ce_dst=we_dst=1 for exactly the next cycle, with addr_dst = word index.
- Unfilled slots of a final partial word are 0.
- After each write, the pack register and byte counter clear.
- The word index starts at 0 on each run.

Timing:
- Let cycle 0 be the cycle in which i_run is sampled.
- Element k is read in cycle k+1 and its data is valid in cycle k+2.
- The write containing element k occurs in cycle k+3 when k completes a word.
- The final write occurs in cycle NUM_ELEMS+2.
- layer_done pulses in cycle NUM_ELEMS+3.
- busy=1 in cycles 1 through NUM_ELEMS+2.

Consecutive runs:
- A new i_run accepted in the cycle after layer_done starts a fresh run at addr_src=0 and addr_dst=0.

Test Plan:
1. SHIFT=8, NUM_ELEMS=8, source = 0x100,0x200,…,0x800 → dst[0]=0x01020304, dst[1]=0x05060708; writes in cycles 6 and 10; layer_done in cycle 11 only.
2. Rounding/saturation, SHIFT=8, inputs 383, 384, 65407, 65408 → bytes 0x01, 0x02, 0xFF, 0xFF. Input 0x7FFFFFFF → 0xFF. Inputs -5 and 0 → 0x00.
3. NUM_ELEMS=6, source 0x100..0x600 → dst[0]=0x01020304, dst[1]=0x05060000; exactly 2 writes; layer_done in cycle 9.
4. Pulse i_run in cycles 3 and 5 while busy → no restart, addr_src sequence is unbroken, exactly one layer_done.
5. Drive reset=0 in cycle 4 of an 8-element run → all outputs 0 immediately. After release and a new i_run, the full correct result is produced with no stray write at addr 1.
6. SHIFT=0, NUM_ELEMS=4, inputs 1, 255, 256, -1 → dst[0]=0x01FFFF00. Then a back-to-back run started the cycle after layer_done rewrites dst[0].

Source files
------------

// File: rtl/fc_requant_pack.sv
// Requantises signed FC-layer accumulators to uint8 and packs four per word
// (first element in bits [31:24]) into the next layer's input BRAM.
module fc_requant_pack #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_ELEMS  = 32,
  parameter int SHIFT      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run,
  output logic                  ce_src,
  output logic                  we_src,
  output logic [ADDR_WIDTH-1:0] addr_src,
  output logic [DATA_WIDTH-1:0] din_src,
  input  logic [DATA_WIDTH-1:0] qout_src,
  output logic                  ce_dst,
  output logic                  we_dst,
  output logic [ADDR_WIDTH-1:0] addr_dst,
  output logic [DATA_WIDTH-1:0] din_dst,
  output logic                  busy,
  output logic                  layer_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ELEMS - 1);
  localparam logic [DATA_WIDTH:0]   ROUND    = (DATA_WIDTH + 1)'((64'd1 << SHIFT) >> 1);

  state_t                  state_q;
  logic                    ceSrc_q;
  logic [ADDR_WIDTH-1:0]   addrSrc_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    valid_q;
  logic [1:0]              byteCnt_q;
  logic [ADDR_WIDTH-1:0]   elemCnt_q;
  logic [ADDR_WIDTH-1:0]   wordIdx_q;
  logic [DATA_WIDTH-1:0]   pack_q;
  logic                    ceDst_q;
  logic [ADDR_WIDTH-1:0]   addrDst_q;
  logic [DATA_WIDTH-1:0]   dinDst_q;
  logic                    lastWord_q;

  logic                    start;
  logic                    lastElem;
  logic                    wordEnd;
  logic [DATA_WIDTH:0]     sum_d;
  logic [DATA_WIDTH:0]     shifted_d;
  logic [7:0]              q_d;
  logic [DATA_WIDTH-1:0]   packed_d;

  assign start    = (state_q == IDLE) && i_run;
  assign lastElem = (elemCnt_q == LAST_IDX);
  assign wordEnd  = valid_q && ((byteCnt_q == 2'd3) || lastElem);

  // 33-bit sum keeps 0x7FFFFFFF plus the rounding offset from wrapping.
  always_comb begin
    sum_d     = {1'b0, qout_src} + ROUND;
    shifted_d = sum_d >> SHIFT;
    q_d       = 8'd0;
    if (qout_src[DATA_WIDTH-1] || (qout_src == '0)) begin
      q_d = 8'd0;
    end else if (shifted_d > (DATA_WIDTH + 1)'(255)) begin
      q_d = 8'hFF;
    end else begin
      q_d = shifted_d[7:0];
    end
  end

  always_comb begin
    packed_d = pack_q;
    case (byteCnt_q)
      2'd0:    packed_d[31:24] = q_d;
      2'd1:    packed_d[23:16] = q_d;
      2'd2:    packed_d[15:8]  = q_d;
      default: packed_d[7:0]   = q_d;
    endcase
  end

  // Control FSM; the last read leaves READ and the final write leaves DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ceSrc_q   <= 1'b0;
      addrSrc_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_run) begin
            state_q   <= READ;
            ceSrc_q   <= 1'b1;
            addrSrc_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        READ: begin
          if (addrSrc_q == LAST_IDX) begin
            state_q   <= DRAIN;
            ceSrc_q   <= 1'b0;
            addrSrc_q <= '0;
          end else begin
            addrSrc_q <= addrSrc_q + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (ceDst_q && lastWord_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pack datapath; a full or final word is registered and written next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      byteCnt_q  <= '0;
      elemCnt_q  <= '0;
      wordIdx_q  <= '0;
      pack_q     <= '0;
      ceDst_q    <= 1'b0;
      addrDst_q  <= '0;
      dinDst_q   <= '0;
      lastWord_q <= 1'b0;
    end else begin
      valid_q   <= ceSrc_q;
      ceDst_q   <= 1'b0;
      addrDst_q <= '0;
      dinDst_q  <= '0;
      if (start) begin
        byteCnt_q  <= '0;
        elemCnt_q  <= '0;
        wordIdx_q  <= '0;
        pack_q     <= '0;
        lastWord_q <= 1'b0;
      end else if (valid_q) begin
        elemCnt_q <= elemCnt_q + ADDR_WIDTH'(1);
        if (wordEnd) begin
          ceDst_q    <= 1'b1;
          addrDst_q  <= wordIdx_q;
          dinDst_q   <= packed_d;
          wordIdx_q  <= wordIdx_q + ADDR_WIDTH'(1);
          pack_q     <= '0;
          byteCnt_q  <= '0;
          lastWord_q <= lastElem;
        end else begin
          pack_q    <= packed_d;
          byteCnt_q <= byteCnt_q + 2'd1;
        end
      end
    end
  end

  assign ce_src     = ceSrc_q;
  assign we_src     = 1'b0;
  assign addr_src   = addrSrc_q;
  assign din_src    = '0;
  assign ce_dst     = ceDst_q;
  assign we_dst     = ceDst_q;
  assign addr_dst   = addrDst_q;
  assign din_dst    = dinDst_q;
  assign busy       = busy_q;
  assign layer_done = done_q;

endmodule

// File: tb/tb_fc_requant_pack.sv
// Bench for fc_requant_pack: three instances (8/8, 6/8, 4/0 elems/shift) checked
// every cycle against a cycle-offset timing model and a byte-level packing model.
module tb_fc_requant_pack;

  logic        clk = 1'b0;
  logic        rstN      [3];
  logic        run       [3];
  logic        ceSrc     [3];
  logic        weSrc     [3];
  logic [11:0] addrSrc   [3];
  logic [31:0] dinSrc    [3];
  logic [31:0] qoutSrc   [3];
  logic        ceDst     [3];
  logic        weDst     [3];
  logic [11:0] addrDst   [3];
  logic [31:0] dinDst    [3];
  logic        busy      [3];
  logic        layerDone [3];

  logic [31:0] srcMem [3][32];
  logic [31:0] dstMem [3][16];
  int          writeCount [3];
  int          tCur [3];

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  fc_requant_pack #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_ELEMS(8), .SHIFT(8)) dutA (
    .clk(clk), .reset(rstN[0]), .i_run(run[0]),
    .ce_src(ceSrc[0]), .we_src(weSrc[0]), .addr_src(addrSrc[0]), .din_src(dinSrc[0]),
    .qout_src(qoutSrc[0]), .ce_dst(ceDst[0]), .we_dst(weDst[0]), .addr_dst(addrDst[0]),
    .din_dst(dinDst[0]), .busy(busy[0]), .layer_done(layerDone[0]));

  fc_requant_pack #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_ELEMS(6), .SHIFT(8)) dutB (
    .clk(clk), .reset(rstN[1]), .i_run(run[1]),
    .ce_src(ceSrc[1]), .we_src(weSrc[1]), .addr_src(addrSrc[1]), .din_src(dinSrc[1]),
    .qout_src(qoutSrc[1]), .ce_dst(ceDst[1]), .we_dst(weDst[1]), .addr_dst(addrDst[1]),
    .din_dst(dinDst[1]), .busy(busy[1]), .layer_done(layerDone[1]));

  fc_requant_pack #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_ELEMS(4), .SHIFT(0)) dutC (
    .clk(clk), .reset(rstN[2]), .i_run(run[2]),
    .ce_src(ceSrc[2]), .we_src(weSrc[2]), .addr_src(addrSrc[2]), .din_src(dinSrc[2]),
    .qout_src(qoutSrc[2]), .ce_dst(ceDst[2]), .we_dst(weDst[2]), .addr_dst(addrDst[2]),
    .din_dst(dinDst[2]), .busy(busy[2]), .layer_done(layerDone[2]));

  function automatic int ne(input int i);
    case (i)
      0:       return 8;
      1:       return 6;
      default: return 4;
    endcase
  endfunction

  function automatic int sh(input int i);
    return (i == 2) ? 0 : 8;
  endfunction

  function automatic logic [31:0] quant(input logic [31:0] v, input int s);
    longint x;
    longint r;
    x = longint'($signed(v));
    if (x <= 0) return 32'd0;
    r = (x + ((s > 0) ? (longint'(1) << (s - 1)) : 0)) >> s;
    if (r > 255) r = 255;
    return 32'(r);
  endfunction

  function automatic logic [31:0] expWord(input int i, input int w);
    logic [31:0] word;
    word = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (4 * w + j < ne(i)) word = word | (quant(srcMem[i][4 * w + j], sh(i)) << (24 - 8 * j));
    end
    return word;
  endfunction

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 70000));
      1:       return ~32'($urandom_range(0, 1000));
      2:       return 32'($urandom);
      default: return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s inst%0d: got 0x%08h, required 0x%08h at %0t",
               name, inst, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int inst);
    @(posedge clk); #1 run[inst] = 1'b1;
    @(posedge clk); #1 run[inst] = 1'b0;
  endtask

  task automatic waitDone(input int inst, input int budget, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (layerDone[inst]) found = 1'b1;
    end
    if (!found) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL doneTimeout inst%0d: got no layer_done, required one within %0d cycles",
               inst, budget);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ceSrc[i]) qoutSrc[i] <= srcMem[i][addrSrc[i][4:0]];
      if (ceDst[i] && weDst[i]) begin
        dstMem[i][addrDst[i][3:0]] <= dinDst[i];
        writeCount[i] <= writeCount[i] + 1;
      end
    end
  end

  // tCur is the cycle offset from the accepted i_run (cycle 0), or -1 when idle.
  always @(negedge clk) begin
    int  t;
    int  n;
    int  k;
    bit  expCe;
    bit  expW;
    for (int i = 0; i < 3; i++) begin
      if (!rstN[i]) begin
        tCur[i] = -1;
        checkOutput("rstCeSrc", i, {31'b0, ceSrc[i]}, 32'd0);
        checkOutput("rstAddrSrc", i, {20'b0, addrSrc[i]}, 32'd0);
        checkOutput("rstCeDst", i, {31'b0, ceDst[i]}, 32'd0);
        checkOutput("rstWeDst", i, {31'b0, weDst[i]}, 32'd0);
        checkOutput("rstAddrDst", i, {20'b0, addrDst[i]}, 32'd0);
        checkOutput("rstDinDst", i, dinDst[i], 32'd0);
        checkOutput("rstBusy", i, {31'b0, busy[i]}, 32'd0);
        checkOutput("rstDone", i, {31'b0, layerDone[i]}, 32'd0);
      end else begin
        if (tCur[i] < 0 && run[i]) tCur[i] = 0;
        t = tCur[i];
        n = ne(i);
        k = t - 3;
        expCe = (t >= 1) && (t <= n);
        expW  = (t >= 3) && (k < n) && ((k % 4 == 3) || (k == n - 1));
        checkOutput("ceSrc", i, {31'b0, ceSrc[i]}, {31'b0, expCe});
        if (expCe) checkOutput("addrSrc", i, {20'b0, addrSrc[i]}, 32'(t - 1));
        checkOutput("weSrc", i, {31'b0, weSrc[i]}, 32'd0);
        checkOutput("dinSrc", i, dinSrc[i], 32'd0);
        checkOutput("busy", i, {31'b0, busy[i]}, {31'b0, (t >= 1) && (t <= n + 2)});
        checkOutput("layerDone", i, {31'b0, layerDone[i]}, {31'b0, t == n + 3});
        checkOutput("ceDst", i, {31'b0, ceDst[i]}, {31'b0, expW});
        checkOutput("weDst", i, {31'b0, weDst[i]}, {31'b0, expW});
        if (expW) begin
          checkOutput("addrDst", i, {20'b0, addrDst[i]}, 32'(k / 4));
          checkOutput("dinDst", i, dinDst[i], expWord(i, k / 4));
        end
        if (t >= 0) tCur[i] = (t == n + 3) ? -1 : t + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int wc;
    int doneCount;
    for (int i = 0; i < 3; i++) begin
      rstN[i] = 1'b0;
      run[i]  = 1'b0;
      tCur[i] = -1;
      for (int e = 0; e < 32; e++) srcMem[i][e] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rstN[i] = 1'b1;
    repeat (2) @(posedge clk);

    // Basic 8-element packing and completion timing.
    for (int e = 0; e < 8; e++) srcMem[0][e] = 32'h100 * (e + 1);
    wc = writeCount[0];
    applyStimulus(0);
    waitDone(0, 40, cyc);
    checkOutput("t1DoneCycle", 0, 32'(cyc), 32'd11);
    checkOutput("t1Dst0", 0, dstMem[0][0], 32'h0102_0304);
    checkOutput("t1Dst1", 0, dstMem[0][1], 32'h0506_0708);
    checkOutput("t1Writes", 0, 32'(writeCount[0] - wc), 32'd2);

    // Rounding and saturation corners.
    srcMem[0][0] = 32'd383;  srcMem[0][1] = 32'd384;
    srcMem[0][2] = 32'd65407; srcMem[0][3] = 32'd65408;
    srcMem[0][4] = 32'h7FFF_FFFF; srcMem[0][5] = 32'hFFFF_FFFB;
    srcMem[0][6] = 32'd0; srcMem[0][7] = 32'd256;
    applyStimulus(0);
    waitDone(0, 40, cyc);
    checkOutput("t2Dst0", 0, dstMem[0][0], 32'h0102_FFFF);
    checkOutput("t2Dst1", 0, dstMem[0][1], 32'hFF00_0001);

    // Partial final word.
    for (int e = 0; e < 6; e++) srcMem[1][e] = 32'h100 * (e + 1);
    wc = writeCount[1];
    applyStimulus(1);
    waitDone(1, 40, cyc);
    checkOutput("t3DoneCycle", 1, 32'(cyc), 32'd9);
    checkOutput("t3Dst0", 1, dstMem[1][0], 32'h0102_0304);
    checkOutput("t3Dst1", 1, dstMem[1][1], 32'h0506_0000);
    checkOutput("t3Writes", 1, 32'(writeCount[1] - wc), 32'd2);

    // i_run pulses while busy are ignored.
    for (int e = 0; e < 8; e++) srcMem[0][e] = 32'h300 * (e + 1);
    wc = writeCount[0];
    applyStimulus(0);
    @(posedge clk); @(posedge clk); #1 run[0] = 1'b1;
    @(posedge clk); #1 run[0] = 1'b0;
    @(posedge clk); #1 run[0] = 1'b1;
    @(posedge clk); #1 run[0] = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (layerDone[0]) doneCount++;
    end
    checkOutput("t4DoneCount", 0, 32'(doneCount), 32'd1);
    checkOutput("t4Writes", 0, 32'(writeCount[0] - wc), 32'd2);
    checkOutput("t4Dst0", 0, dstMem[0][0], 32'h0306_090C);

    // Reset mid-run, then a clean rerun.
    for (int e = 0; e < 8; e++) srcMem[0][e] = randVal();
    wc = writeCount[0];
    applyStimulus(0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1 rstN[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1 rstN[0] = 1'b1;
    applyStimulus(0);
    waitDone(0, 40, cyc);
    checkOutput("t5Writes", 0, 32'(writeCount[0] - wc), 32'd2);
    checkOutput("t5Dst0", 0, dstMem[0][0], expWord(0, 0));
    checkOutput("t5Dst1", 0, dstMem[0][1], expWord(0, 1));

    // SHIFT=0 and a back-to-back run.
    srcMem[2][0] = 32'd1; srcMem[2][1] = 32'd255;
    srcMem[2][2] = 32'd256; srcMem[2][3] = 32'hFFFF_FFFF;
    applyStimulus(2);
    waitDone(2, 40, cyc);
    checkOutput("t6Dst0", 2, dstMem[2][0], 32'h01FF_FF00);
    srcMem[2][0] = 32'd2; srcMem[2][1] = 32'd3;
    srcMem[2][2] = 32'd4; srcMem[2][3] = 32'd5;
    applyStimulus(2);
    waitDone(2, 40, cyc);
    checkOutput("t6DoneCycle", 2, 32'(cyc), 32'd7);
    checkOutput("t6Dst0b", 2, dstMem[2][0], 32'h0203_0405);

    // Randomised runs on every instance.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        for (int e = 0; e < ne(i); e++) srcMem[i][e] = randVal();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        applyStimulus(i);
        waitDone(i, 40, cyc);
        for (int w = 0; w < (ne(i) + 3) / 4; w++)
          checkOutput("randDst", i, dstMem[i][w], expWord(i, w));
      end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
